// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file.
// Default build: REGFILE_BYPASS_EN undefined (no write-through forwarding).
package reg_file_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    function automatic int reg_file_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Post-reset clear sequencer: sweeps every entry to zero, then raises ready.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            idx   <= '0;
        end else if (state == CLEAR) begin
            // idx holds at the last entry; the state change ends the sweep
            if (idx == '1) begin
                state <= READY;
            end else begin
                idx <= idx + ADDR_W'(1);
            end
        end
    end

    assign ready    = (state == READY);
    assign clr_we   = (state == CLEAR);
    assign clr_addr = idx;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one write port.
// Optional macro REGFILE_BYPASS_EN enables write-through forwarding to reads.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    output logic                     ready
);

    localparam int DEPTH = reg_file_depth(ADDR_W);

    logic [DATA_W-1:0] regs [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              we_eff;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    reg_file_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign we_eff  = ready & we & ~((ZERO_REG != 0) && (wa == '0));
    assign wr_en   = clr_we | we_eff;
    assign wr_addr = clr_we ? clr_addr : wa;
    assign wr_data = clr_we ? '0 : wd;

    // No reset on the array so it maps onto RAM; the sequencer clears it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] q;

        assign a = ra[i*ADDR_W +: ADDR_W];

        always_comb begin
            q = '0;
            if (ready && !((ZERO_REG != 0) && (a == '0))) begin
`ifdef REGFILE_BYPASS_EN
                if (we_eff && (a == wa)) begin
                    q = wd;
                end else begin
                    q = regs[a];
                end
`else
                q = regs[a];
`endif
            end
        end

        assign rd[i*DATA_W +: DATA_W] = q;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: clear sweep, writes, zero register, bypass.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ra;
    logic [63:0] rd0;
    logic [63:0] rd1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ready0;
    logic        ready1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd0),
        .we(we), .wa(wa), .wd(wd), .ready(ready0)
    );

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd1),
        .we(we), .wa(wa), .wd(wd), .ready(ready1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        wa = a;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        wa    = '0;
        wd    = '0;
        ra    = {5'd5, 5'd3};
        #23;
        check("rst_ready", {31'd0, ready0}, 32'd0);
        check("rst_rd0", rd0[31:0], 32'd0);
        check("rst_rd1", rd0[63:32], 32'd0);

        // Clear sweep with a dropped write at cycle 10
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            if (n == 10) begin
                we = 1'b1;
                wa = 5'd7;
                wd = 32'hA5A5A5A5;
            end
            @(posedge clk);
            #1;
            we = 1'b0;
            check($sformatf("sweep_ready_%0d", n), {31'd0, ready0}, (n == 32) ? 32'd1 : 32'd0);
        end
        check("sweep_ready_nz", {31'd0, ready1}, 32'd1);

        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            check($sformatf("clr_p0_%0d", i), rd0[31:0], 32'd0);
            check($sformatf("clr_p1_%0d", i), rd0[63:32], 32'd0);
        end

        write(5'd5, 32'hDEADBEEF);
        write(5'd31, 32'h12345678);
        ra = {5'd31, 5'd5};
        #1;
        check("wr_r5", rd0[31:0], 32'hDEADBEEF);
        check("wr_r31", rd0[63:32], 32'h12345678);
        ra = {5'd5, 5'd5};
        #1;
        check("same_addr_p0", rd0[31:0], 32'hDEADBEEF);
        check("same_addr_p1", rd0[63:32], 32'hDEADBEEF);

        write(5'd0, 32'hFFFFFFFF);
        ra = {5'd0, 5'd0};
        #1;
        check("zero_reg_p0", rd0[31:0], 32'd0);
        check("zero_reg_p1", rd0[63:32], 32'd0);
        check("nonzero_reg_p0", rd1[31:0], 32'hFFFFFFFF);

        // Same-cycle read and write of r9
        write(5'd9, 32'h00000001);
        @(negedge clk);
        ra = {5'd5, 5'd9};
        we = 1'b1;
        wa = 5'd9;
        wd = 32'h0000CAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rw_same_cycle", rd0[31:0], 32'h0000CAFE);
`else
        check("rw_same_cycle", rd0[31:0], 32'h00000001);
`endif
        check("rw_other_port", rd0[63:32], 32'hDEADBEEF);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("rw_next_cycle", rd0[31:0], 32'h0000CAFE);

        // Reset pulse between edges, 15 cycles into a fresh sweep
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, ready0}, 32'd0);
        check("mid_rst_rd", rd0[31:0], 32'd0);
        rst_n = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("resweep_ready_%0d", n), {31'd0, ready0}, (n == 32) ? 32'd1 : 32'd0);
        end
        ra = {5'd31, 5'd9};
        #1;
        check("resweep_r9", rd0[31:0], 32'd0);
        check("resweep_r31", rd0[63:32], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
